// File: rtl/shift_register_univ_if.sv
// Bus bundle for shift_register_univ: control, data and status signals.
// master drives the controls; slave is the register itself.
interface shift_register_univ_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             load;
  logic             shift_en;
  logic             dir;
  logic [1:0]       mode;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output load, shift_en, dir, mode, start, count, parallel_in, serial_in,
    input  parallel_out, serial_out, busy, done
  );

  modport slave (
    input  load, shift_en, dir, mode, start, count, parallel_in, serial_in,
    output parallel_out, serial_out, busy, done
  );
endinterface

// File: rtl/shift_register_univ.sv
// Universal shift register with manual shifts and a self-timed burst mode.
// Rotate support (mode 10) is built only when SHIFT_REG_ROTATE_EN is defined; otherwise mode 10 holds.
module shift_register_univ #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_register_univ_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] reg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] count_clamped;
  logic             dir_eff;

  // One shift step; dir 0 moves toward the MSB, dir 1 toward the LSB.
  function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] r, input logic d,
                                                input logic [1:0] m, input logic s);
    logic             fill;
    logic [WIDTH-1:0] res;
    case (m)
      2'b01:   fill = d ? r[WIDTH-1] : 1'b0;
      default: fill = s;
    endcase
    res = d ? {fill, r[WIDTH-1:1]} : {r[WIDTH-2:0], fill};
`ifdef SHIFT_REG_ROTATE_EN
    if (m == 2'b10) res = d ? {r[0], r[WIDTH-1:1]} : {r[WIDTH-2:0], r[WIDTH-1]};
`else
    if (m == 2'b10) res = r;
`endif
    return res;
  endfunction

  assign count_clamped = (bus.count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      reg_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A start request owns the edge, so a coincident shift_en is dropped.
          if (bus.load) begin
            reg_q <= bus.parallel_in;
          end else if (bus.shift_en && !bus.start) begin
            reg_q <= shift_fn(reg_q, bus.dir, bus.mode, bus.serial_in);
          end
          if (bus.start) begin
            if (count_clamped == '0) begin
              done_q <= 1'b1;
            end else begin
              cnt_q   <= count_clamped;
              dir_q   <= bus.dir;
              mode_q  <= bus.mode;
              busy_q  <= 1'b1;
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          if (bus.load) begin
            reg_q   <= bus.parallel_in;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            reg_q <= shift_fn(reg_q, dir_q, mode_q, bus.serial_in);
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dir_eff          = (state_q == StShift) ? dir_q : bus.dir;
  assign bus.parallel_out = reg_q;
  assign bus.serial_out   = dir_eff ? reg_q[0] : reg_q[WIDTH-1];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_shift_register_univ.sv
// Scoreboard bench for shift_register_univ: directed scenarios plus random traffic,
// all checked against an arithmetic reference model.
module tb_shift_register_univ;

  typedef struct packed {
    logic [7:0] po;
    logic       so;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_register_univ_if #(.WIDTH(8), .CNT_W(4)) bus_if ();

  shift_register_univ #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: register value plus remaining burst shifts.
  logic [7:0] m_reg  = 8'h00;
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  bit         m_dir  = 1'b0;
  bit   [1:0] m_mode = 2'b00;
  int         m_rem  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  // Shift expressed as multiply/divide by two with an explicit fill bit.
  function automatic logic [7:0] model_shift(input logic [7:0] r, input bit d, input bit [1:0] m,
                                             input bit s);
    int v;
    int fill;
    v = int'(r);
    if (m == 2'd2) begin
`ifdef SHIFT_REG_ROTATE_EN
      fill = d ? (v % 2) : (v / 128);
`else
      return r;
`endif
    end else if (m == 2'd1) begin
      fill = d ? (v / 128) : 0;
    end else begin
      fill = int'(s);
    end
    if (d) v = v / 2 + fill * 128;
    else   v = (v * 2) % 256 + fill;
    return 8'(v);
  endfunction

  // Drive one cycle's inputs, advance the model over the coming edge, queue the expectation.
  task automatic apply(input bit ld, input bit se, input bit d, input bit [1:0] m, input bit st,
                       input bit [3:0] c, input bit [7:0] p, input bit s);
    exp_t e;
    int   n;
    bus_if.load        = ld;
    bus_if.shift_en    = se;
    bus_if.dir         = d;
    bus_if.mode        = m;
    bus_if.start       = st;
    bus_if.count       = c;
    bus_if.parallel_in = p;
    bus_if.serial_in   = s;
    if (m_busy) begin
      if (ld) begin
        m_reg  = p;
        m_busy = 1'b0;
        m_rem  = 0;
        m_done = 1'b0;
      end else begin
        m_reg  = model_shift(m_reg, m_dir, m_mode, s);
        m_rem  = m_rem - 1;
        m_busy = (m_rem > 0);
        m_done = !m_busy;
      end
    end else begin
      m_done = 1'b0;
      if (ld) m_reg = p;
      else if (se && !st) m_reg = model_shift(m_reg, d, m, s);
      if (st) begin
        n = (int'(c) > 8) ? 8 : int'(c);
        if (n == 0) begin
          m_done = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_rem  = n;
          m_dir  = d;
          m_mode = m;
        end
      end
    end
    e.po   = m_reg;
    e.busy = m_busy;
    e.done = m_done;
    e.so   = (m_busy ? m_dir : d) ? m_reg[0] : m_reg[7];
    exp_q.push_back(e);
  endtask

  task automatic step(input bit ld, input bit se, input bit d, input bit [1:0] m, input bit st,
                      input bit [3:0] c, input bit [7:0] p, input bit s);
    @(negedge clk);
    apply(ld, se, d, m, st, c, p, s);
  endtask

  task automatic idle(input bit d, input bit s);
    step(1'b0, 1'b0, d, 2'd0, 1'b0, 4'd0, 8'h00, s);
  endtask

  task automatic spot(input string name, input logic [7:0] expv);
    @(posedge clk);
    #1;
    check(name, 32'(bus_if.parallel_out), 32'(expv));
  endtask

  // Reset asserted in the middle of the low phase; outputs must clear without waiting for a clock.
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    bus_if.load     = 1'b0;
    bus_if.shift_en = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.dir      = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_parallel_out", 32'(bus_if.parallel_out), 32'h0);
    check("rst_busy", 32'(bus_if.busy), 32'h0);
    check("rst_done", 32'(bus_if.done), 32'h0);
    check("rst_serial_out", 32'(bus_if.serial_out), 32'h0);
    m_reg  = 8'h00;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_rem  = 0;
    e      = '0;
    exp_q.push_back(e);
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 8'h00, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("parallel_out", 32'(bus_if.parallel_out), 32'(e.po));
        check("serial_out", 32'(bus_if.serial_out), 32'(e.so));
        check("busy", 32'(bus_if.busy), 32'(e.busy));
        check("done", 32'(bus_if.done), 32'(e.done));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus_if.load        = 1'b0;
    bus_if.shift_en    = 1'b0;
    bus_if.dir         = 1'b0;
    bus_if.mode        = 2'd0;
    bus_if.start       = 1'b0;
    bus_if.count       = 4'd0;
    bus_if.parallel_in = 8'h00;
    bus_if.serial_in   = 1'b0;
    do_reset();

    // Manual logical left shifts filling with ones.
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 8'hAA, 1'b1);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'd0, 8'h00, 1'b1);
    spot("manual_first", 8'h55);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'd0, 8'h00, 1'b1);
    spot("manual_final", 8'hFF);

    // Arithmetic shifts.
    step(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'd0, 8'h90, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'd0, 8'h00, 1'b0);
    spot("arith_r1", 8'hC8);
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'd0, 8'h00, 1'b1);
    spot("arith_r2", 8'hE4);
    step(1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'd0, 8'h81, 1'b1);
    step(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 4'd0, 8'h00, 1'b1);
    spot("arith_l", 8'h02);

    // Burst with load+start on the same edge; live dir flipped to prove it is latched.
    step(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'd8, 8'h3C, 1'b0);
    for (int i = 0; i < 8; i++) idle(1'b0, 1'b0);
    spot("burst_final", 8'h00);
    idle(1'b0, 1'b0);

    // Rotate (or hold when rotate is not built).
    step(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'd0, 8'h81, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 4'd0, 8'h00, 1'b0);
`ifdef SHIFT_REG_ROTATE_EN
    spot("rotate_l", 8'h03);
`else
    spot("rotate_l", 8'h81);
`endif

    // Burst aborted by load after the third shift.
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'd8, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 8'h5A, 1'b0);
    spot("abort_load", 8'h5A);
    idle(1'b0, 1'b0);

    // Zero-length burst, start-while-busy, over-range count, back-to-back start.
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 4'd0, 8'h00, 1'b1);
    idle(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'd4, 8'h00, 1'b1);
    step(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 4'd2, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'd15, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b1, 1'(i % 2));

    // Reset mid-burst with a full register.
    step(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'd8, 8'hFF, 1'b1);
    do_reset();
    idle(1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(99) < 12, $urandom_range(99) < 50, 1'($urandom_range(1)),
             2'($urandom_range(3)), $urandom_range(99) < 15, 4'($urandom_range(15)),
             8'($urandom_range(255)), 1'($urandom_range(1)));
      end
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) check("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_register_univ.md
# shift_register_univ

Parametrised universal shift register: the next generation of the team's 8-bit load/shift register. It generalises width and adds direction control, logical/arithmetic/rotate fill modes, and a self-timed burst mode that shifts a programmed number of bits and reports completion. It sits between parallel datapaths and serial links, serving as the serializer/deserializer core for SPI/UART-style exercises.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, burst counter width; must satisfy 2^CNT_W > WIDTH
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  parallel load of parallel_in
- shift_en  in  1  single manual shift this edge (ignored while busy)
- dir  in  1  0 = left (toward MSB), 1 = right (toward LSB)
- mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
- start  in  1  begin burst of `count` shifts
- count  in  CNT_W  burst length, 0..WIDTH (values > WIDTH clamp to WIDTH)
- parallel_in  in  WIDTH  load data
- serial_in  in  1  fill bit for logical shifts
- parallel_out  out  WIDTH  register contents
- serial_out  out  1  bit that the next shift will eject: dir=0 → reg[WIDTH-1], dir=1 → reg[0]; combinational from register and effective dir
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after final burst shift

## Operation
- Shift rules: logical left: {reg[W-2:0], serial_in}; logical right: {serial_in, reg[W-1:1]}; arithmetic right: {reg[W-1], reg[W-1:1]}; arithmetic left = logical left with fill 0; rotate left: {reg[W-2:0], reg[W-1]}; rotate right: {reg[0], reg[W-1:1]}.
- Priority per edge: load > burst shift > manual shift_en > hold.
- FSM states: IDLE, SHIFT.
  - IDLE + start (count≠0): latch count, dir, mode → SHIFT, busy=1. Register unchanged on that edge unless load also high (then it loads).
  - IDLE + start with count=0: stay IDLE, done=1 next cycle, no shift.
  - SHIFT: shift each edge using latched dir/mode; decrement counter; after last shift → IDLE, busy=0, done=1 for one cycle.
  - SHIFT + load: register loads, burst aborted → IDLE, no done pulse.
  - start while busy: ignored. shift_en while busy: ignored.
- While busy, serial_out uses latched dir; in IDLE, the live dir input.
- serial_in is sampled live on every burst shift.

## Timing
- Reset (async, immediate): parallel_out=0, serial_out=0, busy=0, done=0, counter=0, FSM=IDLE. Reset mid-burst aborts with no done.
- Manual shift/load: result visible after the sampling edge (1-cycle latency).
- Burst started at edge k with count=N: shifts on edges k+1..k+N; busy high from after k until after k+N; done high for exactly the cycle after edge k+N.
- load+start at the same edge k: register loaded at k, first shift at k+1.
- Back-to-back: start accepted in the cycle done is high (FSM is IDLE).

## Configuration
- SHIFT_REG_ROTATE_EN defined: mode 10 rotates as specified.
- Not defined: rotate logic omitted; mode 10 behaves as hold (no register change, manual or burst; burst still counts down, asserts busy, and pulses done).

## Test plan
- Reset: assert rst mid-cycle with register 0xFF and busy=1 → parallel_out=0x00, busy=0, done=0 immediately; no done after release.
- Manual: load 0xAA, dir=0, mode=00, serial_in=1, 8 × shift_en → serial_out before each shift 1,0,1,0,1,0,1,0; first result 0x55, final 0xFF.
- Arithmetic: load 0x90, dir=1, mode=01, 2 × shift_en → 0xC8 then 0xE4; dir=0 mode=01 on 0x81 → 0x02.
- Burst: load+start same edge, parallel_in=0x3C, count=8, dir=1, mode=00, serial_in=0 → busy 8 cycles, serial_out LSB-first 0,0,1,1,1,1,0,0, done single pulse after 8th shift, parallel_out=0x00.
- Rotate: load 0x81, dir=0, mode=10, one shift → 0x03 with SHIFT_REG_ROTATE_EN; 0x81 without it.
- Boundaries: burst count=8, load 0x5A after 3rd shift → busy drops, no done, parallel_out=0x5A; start with count=0 → done next cycle, register unchanged; start while busy ignored; count=15 with WIDTH=8 → exactly 8 shifts.
